// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receiver (and the matching transmitter).
package uart_pkg;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 5208;
  localparam int UART_DATA_BITS            = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // Offset from the detected start edge to the centre of the start bit.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// CPU-side data/status handshake of the UART receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx_ack;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_overrun;
  logic                      rx_frame_err;
  logic                      rx_busy;

  modport master (
    output rx_ack,
    input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy
  );

  modport slave (
    input  rx_ack,
    output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy
  );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs (serial line, switches).
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-bit validation, mid-bit sampling, framing and overrun flags.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to the start-bit centre to confirm it is still low
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; load byte or flag a framing error
module uart_rx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic      sysclk,
  input  logic      Reset_n,
  input  logic      UART_IN,
  uart_rx_if.slave  bus
);

  localparam int HALF = half_bit(CLKS_PER_BIT);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(UART_DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  uart_rx_state_t            state;
  logic                      rx_s;
  logic                      rx_prev;
  logic [CW-1:0]             cnt;
  logic [BW-1:0]             bitidx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      overrun_q;
  logic                      frame_err_q;
  logic                      busy_q;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (sysclk),
    .rst_n (Reset_n),
    .d     (UART_IN),
    .q     (rx_s)
  );

  always_ff @(posedge sysclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      rx_prev     <= 1'b1;
      cnt         <= '0;
      bitidx      <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_prev <= rx_s;

      // Acknowledge first so a same-cycle load below takes precedence.
      if (bus.rx_ack) begin
        valid_q     <= 1'b0;
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state  <= DATA;
              bitidx <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            shreg  <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            bitidx <= bitidx + 1'b1;
            if (bitidx == BIT_LAST) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          // Leaving at the stop-bit centre lets a back-to-back start edge be seen.
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            state  <= IDLE;
            busy_q <= 1'b0;
            if (rx_s) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
              if (valid_q && !bus.rx_ack) begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_overrun   = overrun_q;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as they are sent, a monitor settles them.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + 1 + HALF + 9 * CPB;

  logic sysclk  = 1'b0;
  logic Reset_n = 1'b0;
  logic UART_IN = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk  (sysclk),
    .Reset_n (Reset_n),
    .UART_IN (UART_IN),
    .bus     (bus)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  // kind: 0 good frame, 1 bad stop bit, 2 glitch
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         start;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    exp_t e;
    e.kind  = stop_ok ? 0 : 1;
    e.data  = d;
    e.start = cyc;
    exp_q.push_back(e);
    UART_IN = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_IN = d[i];
      tick(CPB);
    end
    UART_IN = stop_ok;
    tick(CPB);
    UART_IN = 1'b1;
  endtask

  task automatic glitch(input int len);
    exp_t e;
    e.kind  = 2;
    e.data  = 8'h00;
    e.start = cyc;
    exp_q.push_back(e);
    UART_IN = 1'b0;
    tick(len);
    UART_IN = 1'b1;
    tick(CPB);
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    tick(1);
    bus.rx_ack = 1'b0;
  endtask

  task automatic ack_on_valid();
    int n;
    n = 0;
    while (!bus.rx_valid && n < 20 * CPB) begin
      tick(1);
      n++;
    end
    check("wait_valid_timeout", 32'(bus.rx_valid), 32'd1);
    ack_pulse();
  endtask

  // Reference model of the CPU-visible registers, advanced by acks and completed frames.
  logic [7:0] m_data;
  bit   m_valid, m_ovr, m_ferr, old_valid;
  bit   ack_prev, busy_prev;
  exp_t me;

  always @(negedge sysclk) begin
    if (!Reset_n) begin
      m_data    = 8'h00;
      m_valid   = 1'b0;
      m_ovr     = 1'b0;
      m_ferr    = 1'b0;
      ack_prev  = 1'b0;
      busy_prev = 1'b0;
    end else begin
      old_valid = m_valid;
      if (ack_prev) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
      end
      if (busy_prev && !bus.rx_busy) begin
        if (exp_q.size() == 0) begin
          check("frame_end_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          me = exp_q.pop_front();
          if (me.kind == 2) begin
            check("glitch_busy_short", 32'(cyc <= me.start + 4 + HALF), 32'd1);
          end else begin
            check("latency_window", 32'(cyc >= me.start + LAT && cyc <= me.start + LAT + 2), 32'd1);
            if (me.kind == 0) begin
              if (old_valid && !ack_prev) m_ovr = 1'b1;
              m_data  = me.data;
              m_valid = 1'b1;
            end else begin
              m_ferr = 1'b1;
            end
          end
        end
      end
      check("regs{valid,data,ovr,ferr}",
            32'({bus.rx_valid, bus.rx_data, bus.rx_overrun, bus.rx_frame_err}),
            32'({m_valid, m_data, m_ovr, m_ferr}));
      ack_prev  = bus.rx_ack;
      busy_prev = bus.rx_busy;
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int s;
    bus.rx_ack = 1'b0;
    tick(3);
    check("rst_data", 32'(bus.rx_data), 32'h00);
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_overrun", 32'(bus.rx_overrun), 32'd0);
    check("rst_frame_err", 32'(bus.rx_frame_err), 32'd0);
    check("rst_busy", 32'(bus.rx_busy), 32'd0);
    Reset_n = 1'b1;
    tick(5);

    // Single frame
    send_frame(8'h0C, 1'b1);
    tick(2);
    check("single_data", 32'(bus.rx_data), 32'h0C);
    check("single_valid", 32'(bus.rx_valid), 32'd1);
    check("single_ferr", 32'(bus.rx_frame_err), 32'd0);
    ack_pulse();
    tick(2);

    // Back-to-back with acks
    fork
      begin
        send_frame(8'h0C, 1'b1);
        send_frame(8'h08, 1'b1);
      end
      begin
        ack_on_valid();
        ack_on_valid();
      end
    join
    tick(CPB);
    check("b2b_flags", 32'({bus.rx_valid, bus.rx_overrun, bus.rx_frame_err}), 32'd0);

    // Overrun
    send_frame(8'h0C, 1'b1);
    send_frame(8'h08, 1'b1);
    tick(2);
    check("ovr_data", 32'(bus.rx_data), 32'h08);
    check("ovr_flag", 32'(bus.rx_overrun), 32'd1);
    ack_pulse();
    tick(1);
    check("ovr_cleared", 32'({bus.rx_valid, bus.rx_overrun, bus.rx_frame_err}), 32'd0);

    // Glitch
    glitch(4);
    check("glitch_quiet", 32'({bus.rx_valid, bus.rx_overrun, bus.rx_frame_err, bus.rx_busy}), 32'd0);

    // Framing error leaves held byte untouched
    send_frame(8'h3C, 1'b1);
    send_frame(8'h55, 1'b0);
    tick(CPB);
    check("ferr_flag", 32'(bus.rx_frame_err), 32'd1);
    check("ferr_valid", 32'(bus.rx_valid), 32'd1);
    check("ferr_data", 32'(bus.rx_data), 32'h3C);
    ack_pulse();
    tick(2);

    // Ack in the load cycle
    send_frame(8'h11, 1'b1);
    tick(2);
    s = cyc;
    fork
      send_frame(8'h22, 1'b1);
      begin
        while (cyc < s + 2 + HALF + 9 * CPB) tick(1);
        ack_pulse();
      end
    join
    tick(2);
    check("coll_valid", 32'(bus.rx_valid), 32'd1);
    check("coll_data", 32'(bus.rx_data), 32'h22);
    check("coll_overrun", 32'(bus.rx_overrun), 32'd0);

    // Reset during DATA bit 3 (byte 0x22 still held)
    UART_IN = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      UART_IN = i[0];
      tick(CPB);
    end
    UART_IN = 1'b1;
    tick(CPB / 2);
    check("mid_busy", 32'(bus.rx_busy), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_regs", 32'({bus.rx_valid, bus.rx_data, bus.rx_overrun, bus.rx_frame_err}), 32'd0);
    check("mid_rst_busy", 32'(bus.rx_busy), 32'd0);
    tick(3);
    Reset_n = 1'b1;
    tick(CPB);
    send_frame(8'hA5, 1'b1);
    tick(2);
    check("after_rst_data", 32'(bus.rx_data), 32'hA5);
    ack_pulse();
    tick(2);

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) glitch($urandom_range(1, 5));
      else        send_frame(8'($urandom), r != 1);
      if ($urandom_range(0, 3) != 0) ack_pulse();
      tick($urandom_range(0, 2) * HALF);
    end

    tick(4 * CPB);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(bus.rx_busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
